// File: rtl/question_8_pkg.sv
// Shared constants and types for the question_8 adder/subtractor.
package question_8_pkg;

  // Default operand/result width.
  localparam int unsigned DEFAULT_WIDTH = 32;

  // Width of one carry-lookahead slice.
  localparam int unsigned SLICE_W = 4;

  // Registered status flags produced alongside the result.
  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // Flag values while reset is held: a cleared result reads as zero.
  localparam flags_t FLAGS_RST = '{cout: 1'b0, ovf: 1'b0, zero: 1'b1};

endpackage : question_8_pkg

// File: rtl/question_8_cla4.sv
// 4-bit carry-lookahead slice with group propagate/generate outputs.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       p,
  output logic       g
);

  logic [3:0] pi;
  logic [3:0] gi;
  logic [3:0] c;

  // Per-bit propagate/generate.
  assign pi = a ^ b;
  assign gi = a & b;

  // Flattened lookahead carries into each bit position.
  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);

  // Group terms let a higher level look ahead across whole slices.
  assign p = &pi;
  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
           | (pi[3] & pi[2] & pi[1] & gi[0]);

  assign cout = g | (p & cin);
  assign s    = pi ^ c;

endmodule : cla4

// File: rtl/question_8.sv
// Two's-complement adder/subtractor: combinational sum plus registered result and flags.
module question_8
  import question_8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             zero_q
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;

  // The slice chain only covers whole 4-bit groups.
  if ((WIDTH % SLICE_W) != 0) begin : g_width_check
    $error("question_8: WIDTH must be a multiple of 4");
  end

  logic [WIDTH-1:0]  bx;
  logic [NSLICE:0]   carry;
  logic [NSLICE-1:0] slice_p;
  logic [NSLICE-1:0] slice_g;
  logic [WIDTH-1:0]  sum_d;
  flags_t            flags_d;
  flags_t            flags_q;

  // Subtraction is a + ~b + 1: invert B and feed sub in as the carry.
  assign bx       = b ^ {WIDTH{sub}};
  assign carry[0] = sub;

  // Ripple the carry between 4-bit lookahead slices.
  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    cla4 u_cla4 (
      .a    (a[SLICE_W*i +: SLICE_W]),
      .b    (bx[SLICE_W*i +: SLICE_W]),
      .cin  (carry[i]),
      .s    (sum[SLICE_W*i +: SLICE_W]),
      .cout (carry[i+1]),
      .p    (slice_p[i]),
      .g    (slice_g[i])
    );
  end

  // Group p/g are not needed while carries ripple between slices.
  logic unused_pg;
  assign unused_pg = ^{slice_p, slice_g};

  // Status flags from the combinational result; ovf compares against conditioned B.
  always_comb begin
    flags_d      = FLAGS_RST;
    sum_d        = sum;
    flags_d.cout = carry[NSLICE];
    flags_d.ovf  = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    flags_d.zero = (sum == '0);
  end

  // Output register, captures every edge; reset clears it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      sum_q   <= sum_d;
      flags_q <= flags_d;
    end
  end

  assign cout_q = flags_q.cout;
  assign ovf_q  = flags_q.ovf;
  assign zero_q = flags_q.zero;

endmodule : question_8

// File: tb/tb_question_8.sv
// Self-checking bench for question_8: directed vectors plus random stimulus against an arithmetic model.
module tb_question_8;

  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic [31:0] sum;
  logic        clk;
  logic        rst;
  logic [31:0] sum_q;
  logic        cout_q;
  logic        ovf_q;
  logic        zero_q;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  res_t exp_q;

  question_8 dut (
    .a      (a),
    .b      (b),
    .sub    (sub),
    .sum    (sum),
    .clk    (clk),
    .rst    (rst),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q),
    .zero_q (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic sb);
    res_t   r;
    longint sx;
    longint sy;
    longint d;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sb) begin
      r.s = x - y;
      r.c = (x >= y);
      d   = sx - sy;
    end else begin
      r.s = x + y;
      r.c = ((64'(x) + 64'(y)) >> 32) != 0;
      d   = sx + sy;
    end
    r.v = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    r.z = (r.s == 32'h0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Expected registered state: reset value, else model of inputs at the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.s = 32'h0;
      exp_q.c = 1'b0;
      exp_q.v = 1'b0;
      exp_q.z = 1'b1;
    end else begin
      exp_q = model(a, b, sub);
    end
  end

  // Per-cycle compare of both the combinational and registered outputs.
  always @(negedge clk) begin
    if (chk_en) begin
      res_t r;
      r = model(a, b, sub);
      chk("sum", sum, r.s);
      chk("sum_q", sum_q, exp_q.s);
      chk("cout_q", 32'(cout_q), 32'(exp_q.c));
      chk("ovf_q", 32'(ovf_q), 32'(exp_q.v));
      chk("zero_q", 32'(zero_q), 32'(exp_q.z));
    end
  end

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic comb_vec(input logic [31:0] x, input logic [31:0] y, input logic sb,
                          input logic [31:0] expv);
    res_t r;
    a = x; b = y; sub = sb;
    #1;
    r = model(x, y, sb);
    chk("comb_lit", sum, expv);
    chk("comb_model", sum, r.s);
  endtask

  task automatic reg_vec(input logic [31:0] x, input logic [31:0] y, input logic sb,
                         input logic [31:0] es, input logic ec, input logic ev, input logic ez);
    @(posedge clk); #1;
    a = x; b = y; sub = sb;
    @(posedge clk); #1;
    chk("reg_sum_q", sum_q, es);
    chk("reg_cout_q", 32'(cout_q), 32'(ec));
    chk("reg_ovf_q", 32'(ovf_q), 32'(ev));
    chk("reg_zero_q", 32'(zero_q), 32'(ez));
  endtask

  initial begin
    rst = 1'b1;
    a = 32'h0; b = 32'h0; sub = 1'b0;
    #1;
    chk("rst_sum_q", sum_q, 32'h0);
    chk("rst_cout_q", 32'(cout_q), 32'h0);
    chk("rst_ovf_q", 32'(ovf_q), 32'h0);
    chk("rst_zero_q", 32'(zero_q), 32'h1);

    // Combinational vectors, evaluated while reset is held.
    comb_vec(32'h0,         32'h0,         1'b0, 32'h0);
    comb_vec(32'h1,         32'h0,         1'b0, 32'h1);
    comb_vec(32'h2,         32'h0,         1'b0, 32'h2);
    comb_vec(32'h2,         32'h1,         1'b1, 32'h1);
    comb_vec(32'h2,         32'h2,         1'b1, 32'h0);
    comb_vec(32'h0000_FFFF, 32'h1,         1'b0, 32'h0001_0000);
    comb_vec(32'h0001_0000, 32'h1,         1'b1, 32'h0000_FFFF);
    comb_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE);
    chk("rst_hold_sum_q", sum_q, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Registered flag vectors.
    reg_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    reg_vec(32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    reg_vec(32'h2,         32'h2,         1'b1, 32'h0,         1'b1, 1'b0, 1'b1);
    reg_vec(32'h0,         32'h1,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Async reset mid-cycle after a non-zero result.
    reg_vec(32'h1234_0000, 32'h0000_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_sum_q", sum_q, 32'h0);
    chk("async_zero_q", 32'(zero_q), 32'h1);
    a = 32'h5; b = 32'h3; sub = 1'b0;
    #1;
    chk("rst_track_sum", sum, 32'h8);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_sum_q", sum_q, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_capture", sum_q, 32'h8);

    // Inputs change every cycle; compare process covers latency and flags.
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      a   = rnd_op();
      b   = rnd_op();
      sub = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_question_8
